// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding muxes, ALU, BEQ resolution,
// branch target adder and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [XLEN-1:0]   RD1E,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [REG_AW-1:0] RDE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RDM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);

  logic [XLEN-1:0]   src_a_s;
  logic [XLEN-1:0]   fwd_b_s;
  logic [XLEN-1:0]   src_b_s;
  logic [XLEN-1:0]   alu_result_s;
  logic              zero_s;

  logic              reg_write_d,   reg_write_q;
  logic              mem_write_d,   mem_write_q;
  logic [1:0]        result_src_d,  result_src_q;
  logic [REG_AW-1:0] rd_d,          rd_q;
  logic [XLEN-1:0]   alu_result_d,  alu_result_q;
  logic [XLEN-1:0]   write_data_d,  write_data_q;
  logic [XLEN-1:0]   pc_plus4_d,    pc_plus4_q;

  // Operand selection; the illegal 11 code falls back to the register file.
  always_comb begin
    src_a_s = RD1E;
    fwd_b_s = RD2E;
    case (ForwardAE)
      2'b01:   src_a_s = ResultW;
      2'b10:   src_a_s = alu_result_q;
      default: src_a_s = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b_s = ResultW;
      2'b10:   fwd_b_s = alu_result_q;
      default: fwd_b_s = RD2E;
    endcase
    if (ALUSrcE) begin
      src_b_s = ImmExtE;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // ALU; all arithmetic wraps, shifts use the low five bits of operand B.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    case (ALUControlE)
      3'b000:  alu_result_s = src_a_s + src_b_s;
      3'b001:  alu_result_s = src_a_s - src_b_s;
      3'b010:  alu_result_s = src_a_s & src_b_s;
      3'b011:  alu_result_s = src_a_s | src_b_s;
      3'b100:  alu_result_s = src_a_s ^ src_b_s;
      3'b101: begin
        if ($signed(src_a_s) < $signed(src_b_s)) begin
          alu_result_s = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          alu_result_s = {XLEN{1'b0}};
        end
      end
      3'b110:  alu_result_s = src_a_s << src_b_s[4:0];
      3'b111:  alu_result_s = src_a_s >> src_b_s[4:0];
      default: alu_result_s = {XLEN{1'b0}};
    endcase
  end

  // Same-cycle branch resolution and target for the fetch stage.
  always_comb begin
    zero_s    = (alu_result_s == {XLEN{1'b0}});
    PCSrcE    = BranchE & zero_s;
    PCTargetE = PCE + ImmExtE;
  end

  // EX/MEM next state: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    rd_d         = RDE;
    alu_result_d = alu_result_s;
    write_data_d = fwd_b_s;
    pc_plus4_d   = PCPlus4E;
    if (FlushM) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
      rd_d         = {REG_AW{1'b0}};
    end else if (StallM) begin
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
      rd_d         = rd_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
    end else begin
      reg_write_d  = RegWriteE;
    end
  end

  // EX/MEM register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= {REG_AW{1'b0}};
      alu_result_q <= {XLEN{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      pc_plus4_q   <= {XLEN{1'b0}};
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RDM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        StallM, FlushM;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [4:0]  RDE;
  logic [31:0] PCE, PCPlus4E, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int total = 0;
  int bad   = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RDE(RDE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    StallM = 1'b0; FlushM = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'b00;
    BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 3'b000;
    RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0; RDE = 5'd0;
    PCE = 32'd0; PCPlus4E = 32'd0; ResultW = 32'd0;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  // Put a known value into ALUResultM via a plain ADD of RD1E+0.
  task automatic load_alu_m(input logic [31:0] v);
    idle_inputs();
    RD1E = v;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    total++; if ({RegWriteM, MemWriteM, ResultSrcM, RDM} !== 9'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {RegWriteM, MemWriteM, ResultSrcM, RDM}); end
    total++; if ({ALUResultM, WriteDataM, PCPlus4M} !== 96'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {ALUResultM, WriteDataM, PCPlus4M}); end
    // Random inputs with reset held: nothing must be captured.
    RD1E = $urandom; RD2E = $urandom; RegWriteE = 1'b1; MemWriteE = 1'b1; RDE = 5'd9; PCPlus4E = $urandom;
    step();
    total++; if ({RegWriteM, MemWriteM, RDM, ALUResultM} !== 39'd0) begin bad++; $display("FAIL reset_held got=%h exp=0", {RegWriteM, MemWriteM, RDM, ALUResultM}); end
    // Release, then one edge captures.
    idle_inputs();
    rst = 1'b1;
    RegWriteE = 1'b1; ResultSrcE = 2'b10; RDE = 5'd7; RD1E = 32'd20; RD2E = 32'd22;
    PCPlus4E = 32'h44;
    step();
    total++; if (ALUResultM !== 32'd42) begin bad++; $display("FAIL reset_release_alu got=%h exp=%h", ALUResultM, 32'd42); end
    total++; if ({RegWriteM, ResultSrcM, RDM} !== {1'b1, 2'b10, 5'd7}) begin bad++; $display("FAIL reset_release_ctrl got=%h exp=%h", {RegWriteM, ResultSrcM, RDM}, {1'b1, 2'b10, 5'd7}); end
    total++; if (PCPlus4M !== 32'h44) begin bad++; $display("FAIL reset_release_pc4 got=%h exp=%h", PCPlus4M, 32'h44); end
    // Mid-stream reset clears immediately, no edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({RegWriteM, RDM, ALUResultM, PCPlus4M} !== 70'd0) begin bad++; $display("FAIL reset_async got=%h exp=0", {RegWriteM, RDM, ALUResultM, PCPlus4M}); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_forwarding();
    logic [1:0]  fwd [4]  = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] expv [4] = '{32'd6, 32'd8, 32'd10, 32'd6};
    for (int i = 0; i < 4; i++) begin
      load_alu_m(32'd7);
      idle_inputs();
      RD1E = 32'd5; RD2E = 32'd1; ResultW = 32'd9; ForwardAE = fwd[i];
      step();
      total++; if (ALUResultM !== expv[i]) begin bad++; $display("FAIL fwd_a_%0d got=%h exp=%h", i, ALUResultM, expv[i]); end
    end
    // Operand B forwarding from ALUResultM into the store data path.
    load_alu_m(32'h55);
    idle_inputs();
    RD2E = 32'd1; ForwardBE = 2'b10;
    step();
    total++; if (WriteDataM !== 32'h55 || ALUResultM !== 32'h55) begin bad++; $display("FAIL fwd_b_10 got=%h/%h exp=55/55", WriteDataM, ALUResultM); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] expv [8] = '{32'hFFFFFFF3, 32'hFFFFFFED, 32'h00000000, 32'hFFFFFFF3,
                              32'hFFFFFFF3, 32'h00000001, 32'hFFFFFF80, 32'h1FFFFFFE};
    for (int op = 0; op < 8; op++) begin
      idle_inputs();
      RD1E = 32'hFFFFFFF0; ALUSrcE = 1'b1; ImmExtE = 32'd3; ALUControlE = op[2:0];
      step();
      total++; if (ALUResultM !== expv[op]) begin bad++; $display("FAIL alu_op%0d got=%h exp=%h", op, ALUResultM, expv[op]); end
    end
    // SLT signed: positive vs negative gives 0; shift uses only SrcB[4:0].
    idle_inputs();
    RD1E = 32'd3; RD2E = 32'hFFFFFFF0; ALUControlE = 3'b101;
    step();
    total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL alu_slt_pos got=%h exp=0", ALUResultM); end
    idle_inputs();
    RD1E = 32'h1; RD2E = 32'h24; ALUControlE = 3'b110;
    step();
    total++; if (ALUResultM !== 32'h10) begin bad++; $display("FAIL alu_sll_mask got=%h exp=10", ALUResultM); end
  endtask

  task automatic test_branch();
    idle_inputs();
    BranchE = 1'b1; ALUControlE = 3'b001; RD1E = 32'd4; RD2E = 32'd4;
    PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
    #1;
    total++; if (PCSrcE !== 1'b1) begin bad++; $display("FAIL br_taken got=%b exp=1", PCSrcE); end
    total++; if (PCTargetE !== 32'hF8) begin bad++; $display("FAIL br_target got=%h exp=000000f8", PCTargetE); end
    RD2E = 32'd5;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b exp=0", PCSrcE); end
    RD2E = 32'd4; BranchE = 1'b0;
    #1;
    total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL br_no_branch got=%b exp=0", PCSrcE); end
    PCE = 32'hFFFFFFFC; ImmExtE = 32'h8;
    #1;
    total++; if (PCTargetE !== 32'h4) begin bad++; $display("FAIL br_target_wrap got=%h exp=4", PCTargetE); end
    step();
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'b01; RDE = 5'd12;
    RD1E = 32'd100; RD2E = 32'd23; PCPlus4E = 32'h204;
    step();
    // Change everything and stall for three cycles.
    StallM = 1'b1; RegWriteE = 1'b0; MemWriteE = 1'b1; ResultSrcE = 2'b11; RDE = 5'd3;
    RD1E = 32'd1; RD2E = 32'd1; PCPlus4E = 32'h900;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM, PCPlus4M} !==
                   {1'b1, 1'b0, 2'b01, 5'd12, 32'd123, 32'd23, 32'h204}) begin
        bad++; $display("FAIL stall_hold_%0d got=%h/%h/%h exp=123/23/204 ctrl got=%h", i, ALUResultM, WriteDataM, PCPlus4M, {RegWriteM, MemWriteM, ResultSrcM, RDM});
      end
    end
    // Release the stall: new values captured.
    StallM = 1'b0;
    step();
    total++; if ({MemWriteM, ResultSrcM, RDM, ALUResultM} !== {1'b1, 2'b11, 5'd3, 32'd2}) begin bad++; $display("FAIL stall_release got=%h exp=%h", {MemWriteM, ResultSrcM, RDM, ALUResultM}, {1'b1, 2'b11, 5'd3, 32'd2}); end
    // Flush.
    idle_inputs();
    FlushM = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b10; RDE = 5'd5;
    step();
    total++; if ({RegWriteM, MemWriteM, ResultSrcM, RDM} !== 9'd0) begin bad++; $display("FAIL flush got=%h exp=0", {RegWriteM, MemWriteM, ResultSrcM, RDM}); end
    // Load a live instruction, then flush+stall together.
    FlushM = 1'b0;
    step();
    total++; if ({RegWriteM, MemWriteM, RDM} !== {1'b1, 1'b1, 5'd5}) begin bad++; $display("FAIL flush_reload got=%h exp=%h", {RegWriteM, MemWriteM, RDM}, {1'b1, 1'b1, 5'd5}); end
    FlushM = 1'b1; StallM = 1'b1;
    step();
    total++; if ({RegWriteM, MemWriteM, ResultSrcM, RDM} !== 9'd0) begin bad++; $display("FAIL flush_stall got=%h exp=0", {RegWriteM, MemWriteM, ResultSrcM, RDM}); end
  endtask

  task automatic test_store_path();
    idle_inputs();
    ALUSrcE = 1'b1; ImmExtE = 32'd8; ForwardBE = 2'b01; ResultW = 32'hABCD;
    MemWriteE = 1'b1; RD1E = 32'h100; RD2E = 32'h1111;
    step();
    total++; if (WriteDataM !== 32'hABCD) begin bad++; $display("FAIL store_data got=%h exp=0000abcd", WriteDataM); end
    total++; if (MemWriteM !== 1'b1 || ALUResultM !== 32'h108) begin bad++; $display("FAIL store_addr got=%b/%h exp=1/00000108", MemWriteM, ALUResultM); end
    // x0 destination passes straight through.
    idle_inputs();
    RegWriteE = 1'b1; RDE = 5'd0; RD1E = 32'd9;
    step();
    total++; if ({RegWriteM, RDM, ALUResultM} !== {1'b1, 5'd0, 32'd9}) begin bad++; $display("FAIL x0_pass got=%h exp=%h", {RegWriteM, RDM, ALUResultM}, {1'b1, 5'd0, 32'd9}); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu_ops();
    test_branch();
    test_stall_flush();
    test_store_path();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
